// File: rtl/var_level_table_if.sv
// rtl/var_level_table_if.sv - write, read, backtrack and clear signals of the variable level table
//
// Purpose: bundles every non-clock/reset signal of var_level_table.
// Ports (master drives, slave = table):
//   wr_en/wr_var/wr_val/wr_level   assignment write
//   rd_var                         NUM_RD packed read indices
//   rd_val/rd_unassign/rd_level    registered read data per port
//   bt_start/bt_level              backtrack request and target level
//   clr_start                      flash-clear request
//   bt_busy/bt_done/num_assigned   status
interface var_level_table_if #(
  parameter int MAX_VARS   = 512,
  parameter int VAR_BITS   = $clog2(MAX_VARS),
  parameter int LEVEL_BITS = 8,
  parameter int NUM_RD     = 2
);
  logic                         wr_en;
  logic [VAR_BITS-1:0]          wr_var;
  logic                         wr_val;
  logic [LEVEL_BITS-1:0]        wr_level;
  logic [NUM_RD*VAR_BITS-1:0]   rd_var;
  logic [NUM_RD-1:0]            rd_val;
  logic [NUM_RD-1:0]            rd_unassign;
  logic [NUM_RD*LEVEL_BITS-1:0] rd_level;
  logic                         bt_start;
  logic [LEVEL_BITS-1:0]        bt_level;
  logic                         clr_start;
  logic                         bt_busy;
  logic                         bt_done;
  logic [VAR_BITS:0]            num_assigned;

  modport master (
    output wr_en, wr_var, wr_val, wr_level, rd_var, bt_start, bt_level, clr_start,
    input  rd_val, rd_unassign, rd_level, bt_busy, bt_done, num_assigned
  );

  modport slave (
    input  wr_en, wr_var, wr_val, wr_level, rd_var, bt_start, bt_level, clr_start,
    output rd_val, rd_unassign, rd_level, bt_busy, bt_done, num_assigned
  );
endinterface

// File: rtl/var_level_table.sv
// rtl/var_level_table.sv - per-variable value/level/unassign store with backtrack scan and flash clear
//
// Purpose: assignment table for the SAT core. Holds value, decision level and
// unassigned flag per variable, serves NUM_RD registered read ports with
// write/scan bypass, and runs a one-entry-per-cycle backtrack scan or a
// single-cycle flash clear.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    var_level_table_if.slave (write, read, backtrack, clear, status)
module var_level_table #(
  parameter int MAX_VARS   = 512,
  parameter int VAR_BITS   = $clog2(MAX_VARS),
  parameter int LEVEL_BITS = 8,
  parameter int NUM_RD     = 2
) (
  input  logic             clock,
  input  logic             reset,
  var_level_table_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_CLEAR} state_t;

  localparam logic [VAR_BITS-1:0] LAST_IDX = VAR_BITS'(MAX_VARS - 1);
  localparam logic [VAR_BITS-1:0] IDX_ONE  = VAR_BITS'(1);
  localparam logic [VAR_BITS:0]   CNT_ONE  = (VAR_BITS + 1)'(1);

  state_t                       state_q, state_d;
  logic [VAR_BITS-1:0]          idx_q, idx_d;
  logic [LEVEL_BITS-1:0]        tgt_q, tgt_d;
  logic [VAR_BITS:0]            cnt_q, cnt_d;

  logic [MAX_VARS-1:0]          val_q;
  logic [MAX_VARS-1:0]          unasg_q;
  logic [LEVEL_BITS-1:0]        lvl_q [MAX_VARS];

  logic                         wr_fire;
  logic                         scan_clr;
  logic [VAR_BITS-1:0]          rd_idx [NUM_RD];
  logic [NUM_RD-1:0]            rd_val_q, rd_val_d;
  logic [NUM_RD-1:0]            rd_un_q, rd_un_d;
  logic [NUM_RD*LEVEL_BITS-1:0] rd_lvl_q, rd_lvl_d;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_idx
    assign rd_idx[p] = bus.rd_var[p*VAR_BITS +: VAR_BITS];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    wr_fire  = 1'b0;
    scan_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A write in the same cycle as bt_start lands first; the scan
        // visits it later like any other entry.
        wr_fire = bus.wr_en;
        if (wr_fire && unasg_q[bus.wr_var]) cnt_d = cnt_q + CNT_ONE;
        if (bus.clr_start) begin
          state_d = S_CLEAR;
        end else if (bus.bt_start) begin
          state_d = S_SCAN;
          tgt_d   = bus.bt_level;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        scan_clr = !unasg_q[idx_q] && (lvl_q[idx_q] > tgt_q);
        if (scan_clr) cnt_d = cnt_q - CNT_ONE;
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + IDX_ONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write, scan clear and flash clear never coincide: each belongs to one state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_q   <= '0;
      unasg_q <= '1;
      for (int i = 0; i < MAX_VARS; i++) lvl_q[i] <= '0;
    end else begin
      if (state_q == S_CLEAR) unasg_q <= '1;
      if (wr_fire) begin
        val_q[bus.wr_var]   <= bus.wr_val;
        lvl_q[bus.wr_var]   <= bus.wr_level;
        unasg_q[bus.wr_var] <= 1'b0;
      end
      if (scan_clr) unasg_q[idx_q] <= 1'b1;
    end
  end

  // Read data reflects any update landing on the same edge.
  always_comb begin
    rd_val_d = '0;
    rd_un_d  = '0;
    rd_lvl_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val_d[p]                         = val_q[rd_idx[p]];
      rd_un_d[p]                          = unasg_q[rd_idx[p]];
      rd_lvl_d[p*LEVEL_BITS +: LEVEL_BITS] = lvl_q[rd_idx[p]];
      if (wr_fire && (bus.wr_var == rd_idx[p])) begin
        rd_val_d[p]                         = bus.wr_val;
        rd_un_d[p]                          = 1'b0;
        rd_lvl_d[p*LEVEL_BITS +: LEVEL_BITS] = bus.wr_level;
      end else if ((scan_clr && (idx_q == rd_idx[p])) || (state_q == S_CLEAR)) begin
        rd_un_d[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_val_q <= '0;
      rd_un_q  <= '1;
      rd_lvl_q <= '0;
    end else begin
      rd_val_q <= rd_val_d;
      rd_un_q  <= rd_un_d;
      rd_lvl_q <= rd_lvl_d;
    end
  end

  assign bus.rd_val       = rd_val_q;
  assign bus.rd_unassign  = rd_un_q;
  assign bus.rd_level     = rd_lvl_q;
  assign bus.bt_busy      = (state_q == S_SCAN);
  assign bus.bt_done      = (state_q == S_DONE);
  assign bus.num_assigned = cnt_q;

endmodule
